// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, bus widths, address checks.
package dmem_responder_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [BE_WIDTH-1:0] BE_ALL = BE_WIDTH'(4'hF);

    // Misaligned byte address or any bit set above the implemented word range.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned addr_width);
        return (addr[1:0] != 2'b00) || ((addr >> (addr_width + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Single-port synchronous word RAM with per-byte write enables and registered read data.
module dmem_responder_array
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [BE_WIDTH-1:0]   be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Read data only updates on an enabled load, so it holds through the response phase.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < int'(BE_WIDTH); i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side load/store responder: request latch, wait-state counter, error decode and
// a valid/ready response channel in front of a synchronous word RAM.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [BE_WIDTH-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    logic [1:0]            state;
    logic [1:0]            next_state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  cnt_next;
    logic                  commit;
    logic                  accept;

    logic                  we_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BE_WIDTH-1:0]   be_q;

    logic                  rsp_valid_q;
    logic                  busy_q;
    logic                  ram_en;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign req_ready = (state == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // Next-state and counter logic.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = ST_ACCESS;
                    cnt_next   = CNT_WIDTH'(WAIT_STATES);
                end
            end
            ST_ACCESS: begin
                if (cnt == '0) begin
                    commit     = 1'b1;
                    next_state = ST_RESP;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= cnt_next;
            rsp_valid_q <= (next_state == ST_RESP);
            busy_q      <= (next_state != ST_IDLE);
        end
    end

    // Request latch: only the accepted copy drives the access.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            err_q   <= addr_err(req_addr, ADDR_WIDTH);
            waddr_q <= req_addr[ADDR_WIDTH+1:2];
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    // A reset landing on the commit edge must not write.
    assign ram_en = commit && !rst && !err_q;

    dmem_responder_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (we_q),
        .be    (be_q),
        .addr  (waddr_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign rsp_valid = rsp_valid_q;
    assign busy      = busy_q;
    assign rsp_err   = rsp_valid_q && err_q;
    assign rsp_rdata = (rsp_valid_q && !we_q && !err_q) ? ram_rdata : '0;

endmodule
